shift_deser: RTL

Serial-in, parallel-out receiver for the team's LSB-first synchronous shift link. It is the receiving end of the parallel-load / shift-right register, whose bit 0 is the serial output.
- Collects WIDTH bits strobed by ser_valid into a word, framed by a start pulse.
- Presents each completed word on a one-entry output buffer with a valid/ready handshake.
- Flags words lost when the buffer is full.

---
 rtl/shift_pkg.sv | 17 +
 rtl/shift_deser.sv | 127 ++++++++++++
 2 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the LSB-first synchronous shift link.
// Used by the receiver (shift_deser) and by the matching transmitter.
package shift_pkg;

  // Encodings of the receiver's two states.
  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  // Default word width of the link, shared with the transmitter.
  localparam int unsigned SHIFT_WIDTH = 8;

  typedef enum logic {
    StIdle  = ST_IDLE,
    StShift = ST_SHIFT
  } state_e;

endpackage

// File: rtl/shift_deser.sv
// shift_deser: serial-in, parallel-out receiver for the LSB-first shift link.
// Collects WIDTH bits strobed by ser_valid into a word. The first bit is marked by start.
// Each completed word is presented on a one-entry valid/ready output buffer.
// A word that completes while the buffer is held full is dropped and flagged in overrun.
//
// Ports:
//   clk        system clock, posedge
//   rst        asynchronous active-high reset
//   ser_in     serial data bit, LSB first
//   ser_valid  ser_in holds a valid bit this cycle
//   start      frame marker (bit 0 of a word), only meaningful with ser_valid
//   out_ready  consumer accepts data_out this cycle
//   clr_ovr    clears the sticky overrun flag
//   data_out   received word
//   out_valid  data_out holds an unconsumed word
//   overrun    sticky: a completed word was dropped
//   busy       a frame is in progress
module shift_deser
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = SHIFT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ser_in,
  input  logic             ser_valid,
  input  logic             start,
  input  logic             out_ready,
  input  logic             clr_ovr,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  output logic             overrun,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  // Only the upper WIDTH-1 bits of the shifter are kept. The bit that would land in
  // position 0 is always shifted out before the word completes.
  state_e           state_q, state_d;
  logic [WIDTH-2:0] shreg_q, shreg_d;
  logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;

  logic [WIDTH-1:0] word;
  logic             complete;

  // Full word as it would stand after shifting in the current bit.
  assign word = {ser_in, shreg_q};

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    complete  = 1'b0;

    if (ser_valid) begin
      if (start) begin
        // Fresh frame or resync: the partial word is discarded.
        state_d   = StShift;
        shreg_d   = (WIDTH-1)'({ser_in, {(WIDTH - 1){1'b0}}} >> 1);
        bit_cnt_d = CntW'(1);
      end else if (state_q == StShift) begin
        shreg_d = (WIDTH-1)'(word >> 1);
        if (bit_cnt_q == LastBit) begin
          complete  = 1'b1;
          state_d   = StIdle;
          bit_cnt_d = '0;
        end else begin
          bit_cnt_d = bit_cnt_q + CntW'(1);
        end
      end
    end
  end

  // One-entry output buffer. A drain and a fill on the same edge keep it full.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;

    if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end

    if (clr_ovr) begin
      ovr_d = 1'b0;
    end

    if (complete) begin
      if (!valid_q || out_ready) begin
        data_d  = word;
        valid_d = 1'b1;
      end else begin
        // A drop overrides a simultaneous clear.
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
    end
  end

  assign data_out  = data_q;
  assign out_valid = valid_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q == StShift);

endmodule
